// File: rtl/fpu_shift_pkg.sv
// ----------------------------------------------------------------------------
// fpu_shift_pkg
// Shared definitions for the pipelined mantissa barrel shifter.
//   SHIFT_LEFT / SHIFT_RIGHT : encodings of the Left_Right_i direction bit.
//   calc_nreg()              : number of pipeline registers for a given level
//                              count and levels-per-register grouping.
//   shift_stage_t            : stage payload layout for the default
//                              configuration (SWR=55, EWR=6). The top module
//                              builds the same layout at its own widths.
// Optional feature macro: BARREL_STICKY_EN (see shift_level / top).
// ----------------------------------------------------------------------------
package fpu_shift_pkg;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    localparam int unsigned DEF_SWR = 55;
    localparam int unsigned DEF_EWR = 6;

    // ceil(ewr / lvl_per_reg)
    function automatic int unsigned calc_nreg(input int unsigned ewr,
                                              input int unsigned lvl_per_reg);
        return (ewr + lvl_per_reg - 1) / lvl_per_reg;
    endfunction

    typedef struct packed {
        logic [DEF_SWR-1:0] data;
        logic [DEF_EWR-1:0] amount;
        logic               dir;
        logic               fill;
        logic               sticky;
        logic               valid;
    } shift_stage_t;

endpackage

// File: rtl/shift_level.sv
// ----------------------------------------------------------------------------
// shift_level
// One combinational mux level of the barrel shifter: shifts by 2^K when
// i_amount[K] is set, left or right, inserting i_fill into vacated bits.
// With BARREL_STICKY_EN defined, a right shift also ORs the original data
// bits it discards into the running sticky bit; otherwise sticky passes
// through untouched.
// Ports:
//   i_data   [SWR] data entering this level
//   i_amount [EWR] full shift amount of the beat
//   i_dir         1 = left, 0 = right
//   i_fill        fill bit for vacated positions
//   i_sticky      sticky accumulated by earlier levels
//   o_data   [SWR] data leaving this level
//   o_sticky      updated sticky
// ----------------------------------------------------------------------------
module shift_level
    import fpu_shift_pkg::*;
#(
    parameter int unsigned SWR = 55,
    parameter int unsigned EWR = 6,
    parameter int unsigned K   = 0
) (
    input  logic [SWR-1:0] i_data,
    input  logic [EWR-1:0] i_amount,
    input  logic           i_dir,
    input  logic           i_fill,
    input  logic           i_sticky,
    output logic [SWR-1:0] o_data,
    output logic           o_sticky
);

    localparam int unsigned    STEP = 2 ** K;
    localparam logic [SWR-1:0] ONES = '1;

    logic [SWR-1:0] w_low_mask;
    logic [SWR-1:0] w_high_mask;
    logic [SWR-1:0] w_fill_vec;

    // Shifts by STEP >= SWR yield zero, so the masks saturate to all ones.
    assign w_low_mask  = ~(ONES << STEP);
    assign w_high_mask = ~(ONES >> STEP);
    assign w_fill_vec  = {SWR{i_fill}};

    always_comb begin
        o_data = i_data;
        if (i_amount[K]) begin
            if (i_dir == SHIFT_LEFT) begin
                o_data = (i_data << STEP) | (w_fill_vec & w_low_mask);
            end else begin
                o_data = (i_data >> STEP) | (w_fill_vec & w_high_mask);
            end
        end
    end

`ifdef BARREL_STICKY_EN
    // Earlier levels have already shifted right by amount[K-1:0]; the top
    // cum positions now hold fill bits, which must not reach the sticky.
    localparam logic [EWR-1:0] CUM_MASK = EWR'((2 ** K) - 1);

    logic [EWR-1:0] w_cum;
    logic [SWR-1:0] w_orig_mask;

    assign w_cum       = i_amount & CUM_MASK;
    assign w_orig_mask = ONES >> w_cum;
    assign o_sticky    = i_sticky |
                         (i_amount[K] & (i_dir == SHIFT_RIGHT) &
                          (|(i_data & w_low_mask & w_orig_mask)));
`else
    logic w_unused_amount;
    assign w_unused_amount = ^i_amount;
    assign o_sticky        = i_sticky;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// ----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Parametrised, pipelined significand barrel shifter. EWR mux levels are
// grouped LVL_PER_REG at a time in front of each of NREG pipeline registers,
// so a beat appears on the output NREG cycles after it is accepted. All
// stages advance together whenever the output is empty or being consumed;
// bubbles travel down the pipe with their stage.
// Optional feature macro: BARREL_STICKY_EN -- right shifts accumulate the
// discarded bits into sticky_o; without it sticky_o is always 0.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   flush_i        drop every in-flight beat (and any beat accepted now)
//   in_valid_i     input beat valid
//   in_ready_o     block can accept a beat
//   Shift_Value_i  [EWR] shift amount
//   Shift_Data_i   [SWR] data to shift
//   Left_Right_i   1 = left, 0 = right
//   Bit_Shift_i    fill bit for vacated positions
//   out_valid_o    result valid
//   out_ready_i    consumer accepts the result
//   N_mant_o       [SWR] shifted result
//   sticky_o       OR of bits shifted out (sticky build only)
//   busy_o         any stage holds a valid beat
// ----------------------------------------------------------------------------
module pipelined_barrel_shifter
    import fpu_shift_pkg::*;
#(
    parameter int unsigned SWR         = 55,
    parameter int unsigned EWR         = 6,
    parameter int unsigned LVL_PER_REG = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [EWR-1:0] Shift_Value_i,
    input  logic [SWR-1:0] Shift_Data_i,
    input  logic           Left_Right_i,
    input  logic           Bit_Shift_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [SWR-1:0] N_mant_o,
    output logic           sticky_o,
    output logic           busy_o
);

    localparam int unsigned NREG = calc_nreg(EWR, LVL_PER_REG);

    typedef struct packed {
        logic [SWR-1:0] data;
        logic [EWR-1:0] amount;
        logic           dir;
        logic           fill;
        logic           sticky;
        logic           valid;
    } stage_t;

    stage_t         r_stage   [NREG];
    stage_t         w_src     [NREG];  // payload feeding stage s's level group
    stage_t         w_next    [NREG];  // value stage s loads on advance
    logic [SWR-1:0] w_lvl_in  [EWR];
    logic [SWR-1:0] w_lvl_out [EWR];
    logic           w_stk_in  [EWR];
    logic           w_stk_out [EWR];
    logic           w_en;

    assign w_en       = !r_stage[NREG-1].valid || out_ready_i;
    assign in_ready_o = w_en;

    // Mux levels: the first level of each group reads the stage source,
    // the rest chain from the previous level.
    for (genvar k = 0; k < EWR; k++) begin : g_level
        localparam int unsigned S = k / LVL_PER_REG;
        if (k % LVL_PER_REG == 0) begin : g_head
            assign w_lvl_in[k] = w_src[S].data;
            assign w_stk_in[k] = w_src[S].sticky;
        end else begin : g_chain
            assign w_lvl_in[k] = w_lvl_out[k-1];
            assign w_stk_in[k] = w_stk_out[k-1];
        end

        shift_level #(
            .SWR (SWR),
            .EWR (EWR),
            .K   (k)
        ) u_level (
            .i_data   (w_lvl_in[k]),
            .i_amount (w_src[S].amount),
            .i_dir    (w_src[S].dir),
            .i_fill   (w_src[S].fill),
            .i_sticky (w_stk_in[k]),
            .o_data   (w_lvl_out[k]),
            .o_sticky (w_stk_out[k])
        );
    end

    for (genvar s = 0; s < NREG; s++) begin : g_stage
        localparam int unsigned LAST = ((s + 1) * LVL_PER_REG < EWR) ?
                                       (s + 1) * LVL_PER_REG - 1 : EWR - 1;
        if (s == 0) begin : g_first
            assign w_src[s] = '{data:   Shift_Data_i,
                                amount: Shift_Value_i,
                                dir:    Left_Right_i,
                                fill:   Bit_Shift_i,
                                sticky: 1'b0,
                                valid:  in_valid_i};
        end else begin : g_rest
            assign w_src[s] = r_stage[s-1];
        end

        assign w_next[s] = '{data:   w_lvl_out[LAST],
                             amount: w_src[s].amount,
                             dir:    w_src[s].dir,
                             fill:   w_src[s].fill,
                             sticky: w_stk_out[LAST],
                             valid:  w_src[s].valid};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(NREG); s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(NREG); s++) begin
                if (w_en) begin
                    r_stage[s] <= w_next[s];
                end
                // Flush wins over a same-cycle accept or advance.
                if (flush_i) begin
                    r_stage[s].valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid_o = r_stage[NREG-1].valid;
    assign N_mant_o    = r_stage[NREG-1].data;
    assign sticky_o    = r_stage[NREG-1].sticky;

    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < int'(NREG); s++) begin
            busy_o = busy_o | r_stage[s].valid;
        end
    end

    // Routing fields of the last stage have no consumer.
    logic w_unused;
    assign w_unused = ^{r_stage[NREG-1].amount, r_stage[NREG-1].dir, r_stage[NREG-1].fill};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

    localparam int SWR  = 55;
    localparam int EWR  = 6;
    localparam int LVL  = 2;
    localparam int NREG = 3;

`ifdef BARREL_STICKY_EN
    localparam logic STK_EN = 1'b1;
`else
    localparam logic STK_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           flush_i;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [EWR-1:0] Shift_Value_i;
    logic [SWR-1:0] Shift_Data_i;
    logic           Left_Right_i;
    logic           Bit_Shift_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [SWR-1:0] N_mant_o;
    logic           sticky_o;
    logic           busy_o;

    pipelined_barrel_shifter #(
        .SWR         (SWR),
        .EWR         (EWR),
        .LVL_PER_REG (LVL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .Shift_Value_i (Shift_Value_i),
        .Shift_Data_i  (Shift_Data_i),
        .Left_Right_i  (Left_Right_i),
        .Bit_Shift_i   (Bit_Shift_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .N_mant_o      (N_mant_o),
        .sticky_o      (sticky_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [SWR:0] exp_q [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-by-bit reference: output bit i comes from input bit i-amt (left)
    // or i+amt (right), else the fill bit. Sticky = OR of input bits below amt.
    function automatic logic [SWR:0] model(input logic [SWR-1:0] d, input int amt,
                                           input logic left, input logic fill);
        logic [SWR-1:0] r;
        logic           s;
        s = 1'b0;
        for (int i = 0; i < SWR; i++) begin
            int src;
            src  = left ? i - amt : i + amt;
            r[i] = (src >= 0 && src < SWR) ? d[src] : fill;
        end
        if (STK_EN && !left) begin
            for (int j = 0; j < SWR; j++) begin
                if (j < amt) s = s | d[j];
            end
        end
        return {s, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [SWR-1:0] d, input int amt, input logic left,
                         input logic fill);
        Shift_Data_i  = d;
        Shift_Value_i = EWR'(amt);
        Left_Right_i  = left;
        Bit_Shift_i   = fill;
    endtask

    task automatic drive_random();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        drive(t[SWR-1:0], int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    endtask

    // One clock with scoreboard: sample at negedge, retire/record handshakes.
    task automatic cycle();
        logic [SWR:0] e;
        @(negedge clk);
        if (out_valid_o && out_ready_i) begin
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat: observed data %h with no beat expected", N_mant_o);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_data", 64'(N_mant_o), 64'(e[SWR-1:0]));
                check("sb_sticky", 64'(sticky_o), 64'(e[SWR]));
                n_out++;
            end
        end
        if (in_valid_i && in_ready_o && !flush_i) begin
            exp_q.push_back(model(Shift_Data_i, int'(Shift_Value_i), Left_Right_i, Bit_Shift_i));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) cycle();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Single beat into an empty pipe with out_ready_i=1; checks latency too.
    task automatic directed(input string tag, input logic [SWR-1:0] d, input int amt,
                            input logic left, input logic fill,
                            input logic [SWR-1:0] exp_d, input logic exp_s);
        drive(d, amt, left, fill);
        in_valid_i = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, 64'(in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (NREG - 1) begin
            @(negedge clk);
            check({tag, "_early"}, 64'(out_valid_o), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        check({tag, "_data"}, 64'(N_mant_o), 64'(exp_d));
        check({tag, "_sticky"}, 64'(sticky_o), 64'(exp_s));
        @(posedge clk);
        #1;
    endtask

    logic [SWR-1:0] bp_d [5];
    logic [SWR-1:0] held;
    logic           acc;
    int             idx;

    initial begin
        rst         = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drive('0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_data", 64'(N_mant_o), 64'd0);
        check("rst_sticky", 64'(sticky_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        directed("right4", 55'h40_0000_0000_0001, 4, 1'b0, 1'b0,
                 55'h04_0000_0000_0000, STK_EN);
        directed("left8", 55'h00_0000_0000_00FF, 8, 1'b1, 1'b1,
                 55'h00_0000_0000_FFFF, 1'b0);
        directed("over60", 55'h12_3456_789A_BCDE, 60, 1'b0, 1'b0, '0, STK_EN);
        directed("zero", 55'h2A_5A5A_0F0F_1234, 0, 1'b1, 1'b1,
                 55'h2A_5A5A_0F0F_1234, 1'b0);

        // Backpressure: fill the pipe with out_ready_i low, then hold 4 cycles.
        n_out = 0;
        for (int i = 0; i < 5; i++) bp_d[i] = SWR'({$urandom(), $urandom()});
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(bp_d[i], i + 1, 1'b0, 1'b0);
            in_valid_i = 1'b1;
            cycle();
        end
        drive(bp_d[3], 4, 1'b0, 1'b0);
        #1;
        held = N_mant_o;
        for (int c = 0; c < 4; c++) begin
            check("bp_ready_low", 64'(in_ready_o), 64'd0);
            check("bp_valid_held", 64'(out_valid_o), 64'd1);
            check("bp_data_held", 64'(N_mant_o), 64'(held));
            cycle();
            #1;
        end
        out_ready_i = 1'b1;
        idx = 3;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            drive(bp_d[idx], idx + 1, 1'b0, 1'b0);
            in_valid_i = 1'b1;
            #1;
            acc = in_ready_o;
            cycle();
            if (acc) idx++;
        end
        in_valid_i = 1'b0;
        drain("bp_drain");
        check("bp_count", 64'(n_out), 64'd5);

        // Flush with two beats in flight plus an accept in the same cycle.
        drive_random();
        in_valid_i = 1'b1;
        cycle();
        drive_random();
        cycle();
        check("fl_busy_before", 64'(busy_o), 64'd1);
        drive_random();
        flush_i = 1'b1;
        cycle();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("fl_busy", 64'(busy_o), 64'd0);
        check("fl_valid", 64'(out_valid_o), 64'd0);
        exp_q.delete();
        repeat (4) begin
            @(negedge clk);
            check("fl_no_out", 64'(out_valid_o), 64'd0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-stream.
        in_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(55'h55_5555_5555_5555 ^ SWR'(i), i, 1'b1, 1'b1);
            cycle();
        end
        in_valid_i = 1'b0;
        check("mr_valid_before", 64'(out_valid_o), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid_o), 64'd0);
        check("mr_data", 64'(N_mant_o), 64'd0);
        check("mr_sticky", 64'(sticky_o), 64'd0);
        check("mr_busy", 64'(busy_o), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        directed("post_rst", 55'h0F_0F0F_0F0F_0F0F, 3, 1'b1, 1'b0,
                 55'h78_7878_7878_7878, 1'b0);

        // Random stream with random backpressure.
        n_out = 0;
        for (int c = 0; c < 120; c++) begin
            drive_random();
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain("rnd_drain");
        @(negedge clk);
        check("rnd_idle", 64'(busy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the FPU mantissa barrel shifter.
- Shifts a SWR-bit significand left (normalisation) or right (exponent alignment) by 0..2^EWR-1 positions, with a programmable fill bit.
- Mux levels are grouped into register stages, and a valid/ready handshake with backpressure plus a flush are added.
- Sits between exponent-difference logic and the mantissa adder/normaliser in the add/sub and Karatsuba multiply paths.

Parameters:
- SWR, 55: significand width incl. implicit, guard and round bits.
- EWR, 6: shift-amount width; mux levels = EWR.
- LVL_PER_REG, 2: mux levels per pipeline register, 1..EWR; NREG = ceil(EWR/LVL_PER_REG).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of all in-flight valids.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat.
- Shift_Value_i  in  EWR  shift amount.
- Shift_Data_i  in  SWR  data to shift.
- Left_Right_i  in  1  1 = left, 0 = right.
- Bit_Shift_i  in  1  fill bit inserted into vacated positions.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- N_mant_o  out  SWR  shifted result.
- sticky_o  out  1  OR of bits shifted out (STICKY_EN only, else tied 0).
- busy_o  out  1  any stage holds a valid beat.

Behaviour:
- Reset (rst=0, async): all stage valids 0, all data registers 0, out_valid_o=0, N_mant_o=0, sticky_o=0, busy_o=0.
- in_ready_o = 1 out of reset.
- Global advance enable: en = !out_valid_o || out_ready_i.
  - in_ready_o = en (combinational).
  - Accept occurs when in_valid_i && en.
- On en, every stage register loads from its predecessor, and each valid bit travels with its data. Bubbles are not collapsed. When en=0 all stages hold.
- Latency: NREG cycles from accept to out_valid_o with no stall (defaults: 3). Throughput: 1 beat/cycle.
- Shift levels:
  - Level k shifts by 2^k when Shift_Value_i[k]=1. Shift amount and direction are carried down the pipe with the data.
  - Left shift: shift toward MSB, fill LSBs with Bit_Shift_i.
  - Right shift: shift toward LSB, fill MSBs with Bit_Shift_i.
  - Shift >= SWR: result is all Bit_Shift_i.
  - Shift = 0: data passes through unchanged.
- Output holding: N_mant_o and sticky_o are stable while out_valid_o && !out_ready_i.
- flush_i:
  - Clears all stage valids on the next edge. Data is don't-care.
  - Overrides a simultaneous accept, so the accepted beat is dropped.
  - in_ready_o is unaffected.
- busy_o: OR of all stage valid bits.
- Mid-operation reset: asynchronously discards all beats; no partial output is produced.
- Simultaneous out-handshake and accept: both happen, and the pipe advances by one.

Optional Feature:
- Macro: BARREL_STICKY_EN.
- When defined:
  - Each right-shift level ORs the bits it discards into a per-beat sticky bit that is pipelined with the data.
  - For shifts >= SWR, sticky = OR of the entire input.
  - Left shifts give sticky=0.
  - sticky_o is registered with N_mant_o.
- When undefined: no sticky logic is present and sticky_o = 0.

Decomposition:
- Shared package fpu_shift_pkg:
  - Constants SHIFT_LEFT=1 and SHIFT_RIGHT=0.
  - Function computing NREG from EWR and LVL_PER_REG.
  - Stage-payload typedef {data, amount, dir, fill, sticky, valid}.
- One sub-module shift_level: a single combinational 2^k mux level with sticky contribution, instantiated EWR times via generate.

Test Plan:
- Right shift, defaults: data=0x40_0000_0000_0001, amount=4, fill=0 → after 3 cycles N_mant_o=0x04_0000_0000_0000, sticky_o=1.
- Left shift: data=0x00_0000_0000_00FF, amount=8, fill=1 → N_mant_o=0x00_0000_0000_FFFF, sticky_o=0.
- Oversize shift: amount=60, right, fill=0, data nonzero → N_mant_o=0, sticky_o=1. Amount=0 → data unchanged.
- Backpressure: stream 5 beats, hold out_ready_i=0 for 4 cycles → in_ready_o=0 and output held stable; after release all 5 beats emerge in order with no loss or duplication.
- flush_i asserted with 2 beats in flight plus one accept that cycle → busy_o=0 next cycle, no out_valid_o.
- Async reset pulse mid-stream → outputs 0 immediately; after release, a new beat produces a correct result NREG cycles later.
